// File: rtl/async_receiver_cfg.sv
//----------------------------------------------------------------------------
// async_receiver_cfg
//
// Oversampling asynchronous serial receiver with a configurable frame format
// (5..9 data bits, none/even/odd parity, 1 or 2 stop bits), break detection,
// idle-gap detection and an optional receive FIFO.
//
// Build option: define ASYNC_RX_FIFO_EN to compile in a FIFO_DEPTH-entry
// receive FIFO. Without it each word is presented for a single clk.
//
// Ports
//   clk            : sole clock
//   rst_n          : asynchronous active-low reset
//   rxd            : serial line, idles high, LSB first
//   rx_data        : received word
//   rx_valid       : rx_data / parity_err / frame_err are valid
//   rx_rd          : pop request (FIFO build only)
//   parity_err     : parity mismatch for the current word
//   frame_err      : a stop bit was sampled low for the current word
//   break_det      : one-clk pulse when a break is detected
//   overrun        : one-clk pulse when a word is dropped (FIFO build only)
//   rx_idle        : line has been idle for 4 bit times
//   rx_endofpacket : one-clk pulse on the rising edge of rx_idle
//
// Handshake: in the FIFO build rx_valid is a level meaning "head entry is
// present"; the head is consumed on any clk where rx_valid and rx_rd are both
// high, and rx_rd while rx_valid is low has no effect. In the plain build
// rx_valid is a one-clk strobe that cannot be stalled and rx_rd is ignored.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module async_receiver_cfg #(
   parameter int CLK_FREQUENCY = 50000000,
   parameter int BAUD          = 115200,
   parameter int OVERSAMPLING  = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_rd,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 rx_idle,
   output logic                 rx_endofpacket
);

   // Phase increment, rounded; 21 bits so that a tick-every-clk ratio
   // (increment exactly 2^20) is representable.
   localparam logic [63:0] INC_L = (64'(BAUD) * 64'(OVERSAMPLING) * 64'h100000
                                    + 64'(CLK_FREQUENCY / 2)) / 64'(CLK_FREQUENCY);
   localparam logic [20:0] INC   = INC_L[20:0];

   localparam int OSW = $clog2(OVERSAMPLING);
   localparam logic [OSW-1:0] TC_MAX  = '1;             // OVERSAMPLING-1
   localparam logic [OSW-1:0] TC_HALF = TC_MAX >> 1;    // OVERSAMPLING/2-1
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   localparam int GW = $clog2(4 * OVERSAMPLING + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(4 * OVERSAMPLING);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;
   localparam logic [2:0] ST_BREAK  = 3'd6;

   //-------------------------------------------------------------------------
   // Tick generation: carry-out of a 20-bit phase accumulator
   //-------------------------------------------------------------------------
   logic [19:0] acc;
   logic [20:0] accSum;
   logic        tick;

   assign accSum = {1'b0, acc} + INC;
   assign tick   = accSum[20];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else        acc <= accSum[19:0];
   end

   //-------------------------------------------------------------------------
   // Line conditioning: synchroniser then saturating majority filter.
   // rxBit only moves once the filter has seen three agreeing samples.
   //-------------------------------------------------------------------------
   logic [1:0] syncQ;
   logic [1:0] filt;
   logic       rxBit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncQ <= 2'b11;
         filt  <= 2'b11;
         rxBit <= 1'b1;
      end else if (tick) begin
         syncQ <= {syncQ[0], rxd};
         if (syncQ[1] && filt != 2'b11)       filt <= filt + 2'd1;
         else if (!syncQ[1] && filt != 2'b00) filt <= filt - 2'd1;
         if (filt == 2'b11)      rxBit <= 1'b1;
         else if (filt == 2'b00) rxBit <= 1'b0;
      end
   end

   //-------------------------------------------------------------------------
   // Receive FSM
   //-------------------------------------------------------------------------
   logic [2:0]           state;
   logic [OSW-1:0]       tcnt;
   logic [3:0]           bitCnt;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 parBit;
   logic [DATA_BITS-1:0] wordData;
   logic                 wordPerr;
   logic                 wordFerr;
   logic                 deliver;     // one-clk strobe: word* holds a finished word
   logic                 breakPulse;
   logic                 perrCalc;
   logic                 breakCond;
   logic                 midBit;

   assign midBit = (tcnt == TC_MAX);

   always_comb begin
      perrCalc = 1'b0;
      if (PARITY == 1)      perrCalc = ^{shiftReg, parBit};
      else if (PARITY == 2) perrCalc = ~^{shiftReg, parBit};
   end

   // Evaluated at the first stop sample: an all-zero frame including stop.
   assign breakCond = (shiftReg == '0) && ((PARITY == 0) || !parBit) && !rxBit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tcnt       <= '0;
         bitCnt     <= '0;
         shiftReg   <= '0;
         parBit     <= 1'b0;
         wordData   <= '0;
         wordPerr   <= 1'b0;
         wordFerr   <= 1'b0;
         deliver    <= 1'b0;
         breakPulse <= 1'b0;
      end else begin
         deliver    <= 1'b0;
         breakPulse <= 1'b0;
         if (tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rxBit) begin
                     state <= ST_START;
                     tcnt  <= '0;
                  end
               end
               ST_START: begin
                  // Half a bit in: confirm the start bit and align to mid-bit.
                  if (tcnt == TC_HALF) begin
                     tcnt   <= '0;
                     bitCnt <= '0;
                     state  <= rxBit ? ST_IDLE : ST_DATA;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  tcnt <= tcnt + 1'b1;
                  if (midBit) begin
                     shiftReg <= {rxBit, shiftReg[DATA_BITS-1:1]};
                     if (bitCnt == LAST_BIT) state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                     else                    bitCnt <= bitCnt + 4'd1;
                  end
               end
               ST_PARITY: begin
                  tcnt <= tcnt + 1'b1;
                  if (midBit) begin
                     parBit <= rxBit;
                     state  <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  tcnt <= tcnt + 1'b1;
                  if (midBit) begin
                     if (breakCond) begin
                        breakPulse <= 1'b1;
                        state      <= ST_BREAK;
                     end else begin
                        wordData <= shiftReg;
                        wordPerr <= perrCalc;
                        wordFerr <= ~rxBit;
                        if (STOP_BITS == 2) begin
                           state <= ST_STOP2;
                        end else begin
                           deliver <= 1'b1;
                           state   <= ST_IDLE;
                        end
                     end
                  end
               end
               ST_STOP2: begin
                  tcnt <= tcnt + 1'b1;
                  if (midBit) begin
                     wordFerr <= wordFerr | ~rxBit;
                     deliver  <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
               ST_BREAK: begin
                  if (rxBit) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign break_det = breakPulse;

   //-------------------------------------------------------------------------
   // Idle-gap detection. Reset presets the counter saturated so no
   // end-of-packet is reported before the first frame.
   //-------------------------------------------------------------------------
   logic [GW-1:0] gapCnt;
   logic          idlePrev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gapCnt   <= GAP_MAX;
         idlePrev <= 1'b1;
      end else begin
         idlePrev <= rx_idle;
         if (state != ST_IDLE)                 gapCnt <= '0;
         else if (tick && gapCnt != GAP_MAX)   gapCnt <= gapCnt + 1'b1;
      end
   end

   assign rx_idle        = (gapCnt == GAP_MAX);
   assign rx_endofpacket = rx_idle & ~idlePrev;

   //-------------------------------------------------------------------------
   // Output stage
   //-------------------------------------------------------------------------
`ifdef ASYNC_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wrPtr;
   logic [AW:0]          rdPtr;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 overrunQ;
   logic [DATA_BITS+1:0] head;

   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign pop   = rx_rd && !empty;
   // A simultaneous pop frees the slot the push lands in.
   assign push  = deliver && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         overrunQ <= 1'b0;
      end else begin
         overrunQ <= deliver && full && !pop;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr[AW-1:0]] <= {wordFerr, wordPerr, wordData};
   end

   assign head       = mem[rdPtr[AW-1:0]];
   assign rx_valid   = !empty;
   assign rx_data    = empty ? '0 : head[DATA_BITS-1:0];
   assign parity_err = !empty && head[DATA_BITS];
   assign frame_err  = !empty && head[DATA_BITS+1];
   assign overrun    = overrunQ;
`else
   logic unusedRd;
   localparam int unusedDepth = FIFO_DEPTH;

   assign unusedRd = rx_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= deliver;
         if (deliver) begin
            rx_data    <= wordData;
            parity_err <= wordPerr;
            frame_err  <= wordFerr;
         end
      end
   end

   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_async_receiver_cfg.sv
`timescale 1ns/1ps

module tb_async_receiver_cfg;

`ifdef ASYNC_RX_FIFO_EN
   localparam bit FIFO_BUILD = 1'b1;
`else
   localparam bit FIFO_BUILD = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // stimulus
   logic [2:0] rxd_v;
   logic [2:0] man_rd;
   logic [2:0] auto_pop;
   wire  [2:0] rx_rd_v;

   // observed outputs
   wire  [7:0] data0;
   wire  [6:0] data1;
   wire  [7:0] data2;
   wire  [2:0] valid_v, perr_v, ferr_v, brk_v, ovr_v, idle_v, eop_v;

   assign rx_rd_v = man_rd | (auto_pop & valid_v);

   // dut0: 8N1, dut1: 7E1, dut2: 8N2
   async_receiver_cfg #(.CLK_FREQUENCY(1843200), .BAUD(115200), .OVERSAMPLING(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_v[0]), .rx_data(data0), .rx_valid(valid_v[0]),
      .rx_rd(rx_rd_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .break_det(brk_v[0]),
      .overrun(ovr_v[0]), .rx_idle(idle_v[0]), .rx_endofpacket(eop_v[0]));

   async_receiver_cfg #(.CLK_FREQUENCY(1843200), .BAUD(115200), .OVERSAMPLING(16),
                        .DATA_BITS(7), .PARITY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_v[1]), .rx_data(data1), .rx_valid(valid_v[1]),
      .rx_rd(rx_rd_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .break_det(brk_v[1]),
      .overrun(ovr_v[1]), .rx_idle(idle_v[1]), .rx_endofpacket(eop_v[1]));

   async_receiver_cfg #(.CLK_FREQUENCY(1843200), .BAUD(115200), .OVERSAMPLING(16),
                        .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_v[2]), .rx_data(data2), .rx_valid(valid_v[2]),
      .rx_rd(rx_rd_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .break_det(brk_v[2]),
      .overrun(ovr_v[2]), .rx_idle(idle_v[2]), .rx_endofpacket(eop_v[2]));

   // scoreboard: word = {frame_err, parity_err, data zero-extended to 9 bits}
   logic [10:0] exp_q[$];
   logic [10:0] got_q0[$];
   logic [10:0] got_q1[$];
   logic [10:0] got_q2[$];
   int brk_cnt[3];
   int ovr_cnt[3];
   int eop_cnt[3];
   int total = 0;
   int bad   = 0;

   initial begin
      for (int i = 0; i < 3; i++) begin
         brk_cnt[i] = 0;
         ovr_cnt[i] = 0;
         eop_cnt[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (valid_v[0] && (!FIFO_BUILD || rx_rd_v[0])) got_q0.push_back({ferr_v[0], perr_v[0], 1'b0, data0});
      if (valid_v[1] && (!FIFO_BUILD || rx_rd_v[1])) got_q1.push_back({ferr_v[1], perr_v[1], 2'b00, data1});
      if (valid_v[2] && (!FIFO_BUILD || rx_rd_v[2])) got_q2.push_back({ferr_v[2], perr_v[2], 1'b0, data2});
      for (int i = 0; i < 3; i++) begin
         brk_cnt[i] = brk_cnt[i] + int'(brk_v[i]);
         ovr_cnt[i] = ovr_cnt[i] + int'(ovr_v[i]);
         eop_cnt[i] = eop_cnt[i] + int'(eop_v[i]);
      end
   end

   function automatic int q_size(input int d);
      case (d)
         0:       return got_q0.size();
         1:       return got_q1.size();
         default: return got_q2.size();
      endcase
   endfunction

   function automatic logic [10:0] q_pop(input int d);
      case (d)
         0:       return got_q0.pop_front();
         1:       return got_q1.pop_front();
         default: return got_q2.pop_front();
      endcase
   endfunction

   function automatic logic [10:0] mk(input logic ferr, input logic perr, input logic [8:0] d);
      return {ferr, perr, d};
   endfunction

   // driver tasks
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int d, input logic b);
      rxd_v[d] = b;
      wait_clk(16);
   endtask

   task automatic send_frame(input int d, input logic [8:0] data, input logic par_bit,
                             input logic s1, input logic s2);
      int nbits;
      nbits = (d == 1) ? 7 : 8;
      drive_bit(d, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d, data[i]);
      if (d == 1) drive_bit(d, par_bit);
      drive_bit(d, s1);
      if (d == 2) drive_bit(d, s2);
      rxd_v[d] = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_word(input int d, input string name, input logic [10:0] exp);
      logic [10:0] got;
      logic [10:0] want;
      exp_q.push_back(exp);
      want = exp_q.pop_front();
      if (q_size(d) == 0) begin
         total++;
         bad++;
         $display("FAIL %s actual=no_word expected=%0h", name, want);
      end else begin
         got = q_pop(d);
         check(name, 32'(got), 32'(want));
      end
   endtask

   // vector table
   typedef struct {
      int         dut;
      logic [8:0] data;
      logic       par_bit;
      logic       s1;
      logic       s2;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int b_eop, b_brk, b_ovr;

      vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h0A5)};
      vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h000)};
      vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h0FF)};
      vecs[3]  = '{0, 9'h03C, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 9'h03C)};
      vecs[4]  = '{1, 9'h041, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 9'h041)};
      vecs[5]  = '{1, 9'h041, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h041)};
      vecs[6]  = '{1, 9'h000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 9'h000)};
      vecs[7]  = '{1, 9'h07F, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h07F)};
      vecs[8]  = '{2, 9'h03C, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b0, 9'h03C)};
      vecs[9]  = '{2, 9'h081, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 9'h081)};
      vecs[10] = '{2, 9'h03C, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 9'h03C)};

      rst_n    = 1'b0;
      rxd_v    = 3'b111;
      man_rd   = 3'b000;
      auto_pop = 3'b111;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);

      // reset state
      check("reset rx_valid", 32'(valid_v), 32'h0);
      check("reset rx_data0", 32'(data0), 32'h0);
      check("reset flags", 32'({perr_v, ferr_v, brk_v, ovr_v}), 32'h0);
      check("reset rx_idle", 32'(idle_v), 32'h7);
      check("reset no eop", 32'(eop_cnt[0] + eop_cnt[1] + eop_cnt[2]), 32'h0);

      // table-driven frames
      for (int i = 0; i < 11; i++) begin
         b_eop = eop_cnt[vecs[i].dut];
         send_frame(vecs[i].dut, vecs[i].data, vecs[i].par_bit, vecs[i].s1, vecs[i].s2);
         wait_clk(110);
         check_word(vecs[i].dut, $sformatf("vec%0d word", i), vecs[i].exp);
         check($sformatf("vec%0d extra words", i), 32'(q_size(vecs[i].dut)), 32'h0);
         check($sformatf("vec%0d eop pulses", i), 32'(eop_cnt[vecs[i].dut] - b_eop), 32'h1);
         check($sformatf("vec%0d rx_idle", i), 32'(idle_v[vecs[i].dut]), 32'h1);
      end

      // break: 20 bit times low
      b_brk = brk_cnt[0];
      rxd_v[0] = 1'b0;
      wait_clk(320);
      rxd_v[0] = 1'b1;
      wait_clk(48);
      check("break pulses", 32'(brk_cnt[0] - b_brk), 32'h1);
      check("break no word", 32'(q_size(0)), 32'h0);
      send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1);
      wait_clk(110);
      check_word(0, "after break word", mk(1'b0, 1'b0, 9'h055));

      // 8-clk glitch is rejected as a false start
      b_brk = brk_cnt[0];
      rxd_v[0] = 1'b0;
      wait_clk(8);
      rxd_v[0] = 1'b1;
      wait_clk(110);
      check("glitch no word", 32'(q_size(0)), 32'h0);
      check("glitch no break", 32'(brk_cnt[0] - b_brk), 32'h0);
      check("glitch back idle", 32'(idle_v[0]), 32'h1);
      send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1);
      wait_clk(110);
      check_word(0, "after glitch word", mk(1'b0, 1'b0, 9'h05A));

      // reset in the middle of a frame
      for (int i = 0; i < 5; i++) drive_bit(0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("midreset valid", 32'(valid_v[0]), 32'h0);
      check("midreset outputs", 32'({data0, perr_v[0], ferr_v[0], brk_v[0], ovr_v[0], eop_v[0]}), 32'h0);
      check("midreset idle", 32'(idle_v[0]), 32'h1);
      rxd_v[0] = 1'b1;
      wait_clk(4);
      b_eop = eop_cnt[0];
      rst_n = 1'b1;
      wait_clk(110);
      check("midreset no word", 32'(q_size(0)), 32'h0);
      check("midreset no eop", 32'(eop_cnt[0] - b_eop), 32'h0);
      send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
      wait_clk(110);
      check_word(0, "after reset word", mk(1'b0, 1'b0, 9'h0C3));

      // burst of five words with nobody reading
      auto_pop[0] = 1'b0;
      b_ovr = ovr_cnt[0];
      for (int v = 1; v <= 5; v++) send_frame(0, 9'(v), 1'b0, 1'b1, 1'b1);
      wait_clk(110);
`ifdef ASYNC_RX_FIFO_EN
      check("burst overrun", 32'(ovr_cnt[0] - b_ovr), 32'h1);
      check("burst full valid", 32'(valid_v[0]), 32'h1);
      for (int p = 0; p < 4; p++) begin
         man_rd[0] = 1'b1;
         wait_clk(1);
         man_rd[0] = 1'b0;
         wait_clk(1);
      end
      for (int v = 1; v <= 4; v++) check_word(0, $sformatf("burst pop%0d", v), mk(1'b0, 1'b0, 9'(v)));
      check("burst drained valid", 32'(valid_v[0]), 32'h0);
      man_rd[0] = 1'b1;
      wait_clk(2);
      man_rd[0] = 1'b0;
`else
      check("burst overrun", 32'(ovr_cnt[0] - b_ovr), 32'h0);
      for (int v = 1; v <= 5; v++) check_word(0, $sformatf("burst word%0d", v), mk(1'b0, 1'b0, 9'(v)));
      check("burst strobe low", 32'(valid_v[0]), 32'h0);
`endif
      check("burst no extra", 32'(q_size(0)), 32'h0);
      auto_pop[0] = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/async_receiver_cfg.md
ASYNC_RECEIVER_CFG -- requirements
Module: async_receiver_cfg

Interface
REQ-001 Parameter CLK_FREQUENCY, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter OVERSAMPLING, default 16, ticks per bit; power of 2, minimum 8.
REQ-004 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-005 Parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-006 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-007 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2; used only with the FIFO compiled in.
REQ-008 Port clk, input, 1 bit, sole clock.
REQ-009 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 Port rxd, input, 1 bit, asynchronous serial line; idles high.
REQ-011 Port rx_data, output, DATA_BITS bits, received word, LSB first on the line.
REQ-012 Port rx_valid, output, 1 bit, rx_data and the error flags are valid.
REQ-013 Port rx_rd, input, 1 bit, pop request (FIFO build only).
REQ-014 Port parity_err, output, 1 bit, parity mismatch for the current word.
REQ-015 Port frame_err, output, 1 bit, a stop bit was sampled low for the current word.
REQ-016 Port break_det, output, 1 bit, one-cycle pulse when a break is detected.
REQ-017 Port overrun, output, 1 bit, one-cycle pulse when a word is dropped.
REQ-018 Port rx_idle, output, 1 bit, line has been idle for the gap time.
REQ-019 Port rx_endofpacket, output, 1 bit, one-cycle pulse on the rising edge of rx_idle.

Function
REQ-020 Tick generation SHALL use a 20-bit phase accumulator.
  - Increment = round(BAUD*OVERSAMPLING*2^20/CLK_FREQUENCY).
  - tick = accumulator carry-out.
REQ-021 Line conditioning:
  - rxd passes a 2-flop synchroniser (reset 1s) clocked on tick.
  - It then feeds a saturating 2-bit majority filter (reset 2'b11).
  - rx_bit changes only when the filter saturates (00 or 11).
REQ-022 Receive FSM states and transitions:
  - IDLE -> START on rx_bit == 0.
  - START: wait OVERSAMPLING/2 ticks, then re-sample; if rx_bit == 1 (false start) -> IDLE, else -> DATA.
  - DATA -> PARITY, or -> STOP if PARITY == 0.
  - PARITY -> STOP.
  - STOP -> STOP2 if STOP_BITS == 2, else -> IDLE.
  - STOP2 -> IDLE.
  - BREAK -> IDLE once rx_bit == 1.
REQ-023 From START, every subsequent sample is taken exactly OVERSAMPLING ticks after the previous one (mid-bit); DATA takes DATA_BITS samples.
REQ-024 Parity check: even = XOR of data and parity bits equals 0; odd = that XOR equals 1; parity_err set on mismatch.
REQ-025 Framing: any stop sample equal to 0 sets frame_err.
REQ-026 Break:
  - Condition: all data bits 0, parity bit 0 (if present), and first stop bit 0.
  - Action: pulse break_det, deliver no word, enter BREAK instead of STOP/STOP2.
REQ-027 Word delivery occurs 1 clk after the final stop sample; the word is delivered even when parity_err or frame_err is set.
REQ-028 Gap counter:
  - Counts ticks while in IDLE; cleared in any other state.
  - Saturates at 4*OVERSAMPLING.
  - rx_idle = counter saturated.
REQ-029 rx_endofpacket SHALL pulse one clk on the 0->1 transition of rx_idle only.

Reset
REQ-030 rst_n low SHALL asynchronously:
  - set the FSM to IDLE and clear the accumulator and bit counters;
  - empty the FIFO;
  - drive rx_data, rx_valid, parity_err, frame_err, break_det, overrun and rx_endofpacket to 0.
REQ-031 Reset SHALL preset the gap counter to saturated, so rx_idle = 1 with no rx_endofpacket until a frame has been received.
REQ-032 Reset asserted mid-frame SHALL discard the partial word; reception restarts at the next falling edge after release.

Configuration
REQ-033 Macro ASYNC_RX_FIFO_EN.
  - Defined: FIFO_DEPTH-entry FIFO of {frame_err, parity_err, data}.
    - rx_valid = FIFO not empty; outputs show the head entry.
    - rx_rd with rx_valid pops the head; rx_rd with rx_valid low is ignored.
    - Push while full: word dropped, overrun pulses, unless rx_rd is high in the same cycle, in which case push and pop both occur.
  - Undefined:
    - rx_valid, rx_data and flags are registered and valid for exactly one clk per word.
    - rx_rd is ignored; overrun is tied to 0.

Verification
Bench settings: CLK_FREQUENCY=1843200, BAUD=115200, OVERSAMPLING=16, so tick every clk and bit = 16 clk.
REQ-034 Defaults, no FIFO; send 0xA5 8N1 -> one rx_valid pulse, rx_data=0xA5, no error flags; after 64 idle ticks, rx_idle=1 and one rx_endofpacket pulse.
REQ-035 PARITY=1, DATA_BITS=7; send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-036 STOP_BITS=2; send 0x3C with second stop bit low -> rx_data=0x3C, frame_err=1.
REQ-037 Hold rxd low for 20 bit times -> break_det pulses once, no rx_valid; rxd high then 0x55 -> rx_data=0x55.
REQ-038 FIFO build, FIFO_DEPTH=4, rx_rd=0; send 0x01..0x05 -> overrun pulses on 0x05; pops return 0x01..0x04, then rx_valid=0.
REQ-039 8-clk low glitch on rxd -> no word received, FSM back in IDLE; rst_n pulsed mid-frame -> no word, outputs 0, next frame received correctly.
